// File: rtl/tft_pkg.sv
// Shared types and constants for the TFT receive capture path.
package tft_pkg;

    localparam int COORD_W = 11;

    localparam logic [COORD_W-1:0] H_VALID_DEF = 11'd480;
    localparam logic [COORD_W-1:0] V_VALID_DEF = 11'd800;
    localparam logic [COORD_W-1:0] COORD_INV   = 11'h7ff;
    localparam logic [COORD_W-1:0] COORD_MAX   = 11'h7ff;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_LINE,
        ST_HBLANK
    } state_t;

    // One sampled pixel-clock slot after the input register stage.
    typedef struct packed {
        logic        vs_fall;
        logic        de_rise;
        logic        de_fall;
        logic        de;
        logic [15:0] rgb_dat;
    } sync_t;

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == COORD_MAX) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/tft_sync_edge.sv
// Input register stage with vsync-fall and de-rise/fall detection.
// Latency: 1 clock from input pins to registered level; edges are combinational on that stage.
// Backpressure: none, free-running sample of the pixel stream.
module tft_sync_edge
    import tft_pkg::*;
(
    input  logic        tft_clk_9m,
    input  logic        sys_rst_n,
    input  logic [15:0] rgb_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    output sync_t       evt
);

    logic        vs_s1;
    logic        de_s1;
    logic        vs_s1_prev;
    logic        de_s1_prev;
    logic [15:0] rgb_s1;

    // hsync carries no information in DE mode; kept on the port for pin compatibility.
    logic unused_hsync;
    assign unused_hsync = hsync_in;

    // Reset to the idle-line levels so release never fakes an edge.
    always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_s1      <= 1'b1;
            de_s1      <= 1'b0;
            vs_s1_prev <= 1'b1;
            de_s1_prev <= 1'b0;
            rgb_s1     <= 16'd0;
        end else begin
            vs_s1      <= vsync_in;
            de_s1      <= de_in;
            rgb_s1     <= rgb_in;
            vs_s1_prev <= vs_s1;
            de_s1_prev <= de_s1;
        end
    end

    always_comb begin
        evt         = '0;
        evt.vs_fall = vs_s1_prev & ~vs_s1;
        evt.de_rise = ~de_s1_prev & de_s1;
        evt.de_fall = de_s1_prev & ~de_s1;
        evt.de      = de_s1;
        evt.rgb_dat = rgb_s1;
    end

endmodule

// File: rtl/tft_rx_capture.sv
// DE-mode RGB565 capture: pixel coordinates, frame markers, geometry check, lock status.
// Latency: 2 clocks from input sample to every output.
// Backpressure: none, outputs follow the incoming pixel clock unconditionally.
module tft_rx_capture
    import tft_pkg::*;
#(
    parameter logic [COORD_W-1:0] H_VALID     = H_VALID_DEF,
    parameter logic [COORD_W-1:0] V_VALID     = V_VALID_DEF,
    parameter int                 LOCK_FRAMES = 2
)(
    input  logic               tft_clk_9m,
    input  logic               sys_rst_n,
    input  logic [15:0]        rgb_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               de_in,
    output logic [15:0]        pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    output logic               sof,
    output logic               eol,
    output logic               frame_done,
    output logic [COORD_W-1:0] meas_h,
    output logic [COORD_W-1:0] meas_v,
    output logic               frame_err,
    output logic [7:0]         err_cnt,
    output logic               locked
);

    localparam int             GW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]  LOCK_G = GW'(LOCK_FRAMES);

    sync_t evt;

    tft_sync_edge u_sync_edge (
        .tft_clk_9m (tft_clk_9m),
        .sys_rst_n  (sys_rst_n),
        .rgb_in     (rgb_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .de_in      (de_in),
        .evt        (evt)
    );

    state_t             state, state_nxt, st_eff;
    logic [COORD_W-1:0] x_cnt, x_nxt;
    logic [COORD_W-1:0] y_cnt, y_nxt;
    logic [COORD_W-1:0] line_cnt, line_nxt;
    logic [COORD_W-1:0] ex, ey;
    logic [COORD_W-1:0] meas_h_nxt, meas_v_nxt;
    logic               line_bad, line_bad_nxt;
    logic               close_frame, frame_bad;
    logic               emit_try, emit;
    logic [GW-1:0]      good_cnt, good_nxt, good_inc;
    logic               locked_nxt, done_nxt, err_nxt;
    logic [7:0]         err_cnt_nxt;

    always_comb begin
        state_nxt    = state;
        st_eff       = state;
        x_nxt        = x_cnt;
        y_nxt        = y_cnt;
        line_nxt     = line_cnt;
        line_bad_nxt = line_bad;
        good_nxt     = good_cnt;
        locked_nxt   = locked;
        err_cnt_nxt  = err_cnt;
        meas_h_nxt   = meas_h;
        meas_v_nxt   = meas_v;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        emit_try     = 1'b0;
        emit         = 1'b0;
        ex           = x_cnt;
        ey           = y_cnt;

        close_frame = evt.vs_fall && (state != ST_IDLE);
        frame_bad   = line_bad || (line_cnt != V_VALID) || (state == ST_LINE);
        good_inc    = (good_cnt == LOCK_G) ? good_cnt : good_cnt + GW'(1);

        // Frame close is resolved before pixel handling so a same-cycle
        // de rise becomes pixel (0,0) of the new frame.
        if (evt.vs_fall) begin
            st_eff       = ST_VBLANK;
            y_nxt        = '0;
            line_nxt     = '0;
            line_bad_nxt = 1'b0;
        end

        if (close_frame) begin
            meas_v_nxt = line_cnt;
            done_nxt   = 1'b1;
            if (frame_bad) begin
                err_nxt     = 1'b1;
                good_nxt    = '0;
                locked_nxt  = 1'b0;
                err_cnt_nxt = (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
            end else begin
                good_nxt   = good_inc;
                locked_nxt = (good_inc >= LOCK_G);
            end
        end

        state_nxt = st_eff;
        case (st_eff)
            ST_VBLANK, ST_HBLANK: begin
                if (evt.de_rise) begin
                    state_nxt = ST_LINE;
                    ex        = '0;
                    ey        = (st_eff == ST_HBLANK) ? sat_inc(y_cnt) : '0;
                    y_nxt     = ey;
                    emit_try  = 1'b1;
                end
            end
            ST_LINE: begin
                if (evt.de_fall) begin
                    state_nxt  = ST_HBLANK;
                    meas_h_nxt = x_cnt;
                    line_nxt   = sat_inc(line_cnt);
                    if (x_cnt != H_VALID) begin
                        line_bad_nxt = 1'b1;
                    end
                end else if (evt.de) begin
                    emit_try = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (emit_try) begin
            x_nxt = sat_inc(ex);
            emit  = (ex < H_VALID) && (ey < V_VALID);
        end
    end

    always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            line_cnt <= '0;
            line_bad <= 1'b0;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            x_cnt    <= x_nxt;
            y_cnt    <= y_nxt;
            line_cnt <= line_nxt;
            line_bad <= line_bad_nxt;
            good_cnt <= good_nxt;
        end
    end

    always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data   <= 16'd0;
            pix_x      <= COORD_INV;
            pix_y      <= COORD_INV;
            pix_valid  <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            meas_h     <= '0;
            meas_v     <= '0;
            err_cnt    <= 8'd0;
            locked     <= 1'b0;
        end else begin
            pix_data   <= emit ? evt.rgb_dat : 16'd0;
            pix_x      <= emit ? ex : COORD_INV;
            pix_y      <= emit ? ey : COORD_INV;
            pix_valid  <= emit;
            sof        <= emit && (ex == '0) && (ey == '0);
            eol        <= emit && (ex == H_VALID - 11'd1);
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            meas_h     <= meas_h_nxt;
            meas_v     <= meas_v_nxt;
            err_cnt    <= err_cnt_nxt;
            locked     <= locked_nxt;
        end
    end

endmodule

// File: tb/tb_tft_rx_capture.sv
// Randomised DE-mode video against a frame-level reference model of tft_rx_capture.
module tb_tft_rx_capture;

    localparam int H     = 8;
    localparam int V     = 5;
    localparam int LOCKF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rgb = 16'd0;
    logic        hs = 1'b1, vs = 1'b1, de = 1'b0;
    logic [15:0] pix_data;
    logic [10:0] pix_x, pix_y, meas_h, meas_v;
    logic        pix_valid, sof, eol, frame_done, frame_err, locked;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    tft_rx_capture #(
        .H_VALID     (11'(H)),
        .V_VALID     (11'(V)),
        .LOCK_FRAMES (LOCKF)
    ) dut (
        .tft_clk_9m (clk),
        .sys_rst_n  (rst_n),
        .rgb_in     (rgb),
        .hsync_in   (hs),
        .vsync_in   (vs),
        .de_in      (de),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .eol        (eol),
        .frame_done (frame_done),
        .meas_h     (meas_h),
        .meas_v     (meas_v),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .locked     (locked)
    );

    typedef struct packed {
        logic        v;
        logic [10:0] x;
        logic [10:0] y;
        logic [15:0] d;
        logic        sof;
        logic        eol;
        logic        fd;
        logic        fe;
        logic [10:0] mh;
        logic [10:0] mv;
        logic [7:0]  ec;
        logic        lk;
    } snap_t;

    snap_t q[$];
    int    n_chk = 0;
    int    n_pass = 0;

    // Reference model: reasons about de runs and vsync falls within a frame.
    bit    m_sync, m_prev_vs, m_prev_de, m_in_run, m_badl;
    int    m_run, m_started, m_done, m_good;
    snap_t m_st;

    task automatic model_reset();
        m_sync = 0; m_prev_vs = 1; m_prev_de = 0; m_in_run = 0; m_badl = 0;
        m_run = 0; m_started = 0; m_done = 0; m_good = 0;
        m_st = '0;
        m_st.x = 11'h7ff;
        m_st.y = 11'h7ff;
        q.delete();
        q.push_back(m_st);
        q.push_back(m_st);
    endtask

    task automatic model_step(input bit vsv, input bit dev, input logic [15:0] d, output snap_t s);
        bit vsf, der, def;
        s = m_st;
        s.v = 0; s.x = 11'h7ff; s.y = 11'h7ff; s.d = 16'd0;
        s.sof = 0; s.eol = 0; s.fd = 0; s.fe = 0;
        vsf = m_prev_vs && !vsv;
        der = !m_prev_de && dev;
        def = m_prev_de && !dev;
        if (vsf) begin
            if (m_sync) begin
                s.fd = 1;
                s.mv = 11'(m_done);
                if (m_badl || (m_done != V) || m_in_run) begin
                    s.fe = 1;
                    if (s.ec != 8'd255) s.ec = s.ec + 8'd1;
                    m_good = 0;
                    s.lk = 0;
                end else begin
                    m_good++;
                    if (m_good >= LOCKF) s.lk = 1;
                end
            end
            m_sync = 1; m_done = 0; m_started = 0; m_badl = 0; m_in_run = 0;
        end
        if (m_sync) begin
            if (der) begin
                m_in_run = 1; m_run = 0; m_started++;
            end
            if (def && m_in_run) begin
                m_in_run = 0;
                s.mh = 11'(m_run);
                m_done++;
                if (m_run != H) m_badl = 1;
            end
            if (dev && m_in_run) begin
                if (m_run < H && (m_started - 1) < V) begin
                    s.v = 1;
                    s.x = 11'(m_run);
                    s.y = 11'(m_started - 1);
                    s.d = d;
                    s.sof = (m_run == 0) && (m_started == 1);
                    s.eol = (m_run == H - 1);
                end
                m_run++;
            end
        end
        m_prev_vs = vsv;
        m_prev_de = dev;
        m_st = s;
    endtask

    task automatic check_outputs();
        snap_t e, a;
        e = q.pop_front();
        a.v = pix_valid; a.x = pix_x; a.y = pix_y;
        a.d = e.v ? pix_data : e.d;
        a.sof = sof; a.eol = eol; a.fd = frame_done; a.fe = frame_err;
        a.mh = meas_h; a.mv = meas_v; a.ec = err_cnt; a.lk = locked;
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL cycle t=%0t got v=%b x=%0d y=%0d d=%h sof=%b eol=%b fd=%b fe=%b mh=%0d mv=%0d ec=%0d lk=%b required v=%b x=%0d y=%0d d=%h sof=%b eol=%b fd=%b fe=%b mh=%0d mv=%0d ec=%0d lk=%b",
                      $time, a.v, a.x, a.y, a.d, a.sof, a.eol, a.fd, a.fe, a.mh, a.mv, a.ec, a.lk,
                      e.v, e.x, e.y, e.d, e.sof, e.eol, e.fd, e.fe, e.mh, e.mv, e.ec, e.lk);
    endtask

    task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %0h required %0h", nm, got, want);
    endtask

    task automatic step(input bit vsv, input bit dev);
        logic [15:0] d;
        snap_t s;
        d = 16'($urandom);
        @(negedge clk);
        check_outputs();
        vs = vsv;
        de = dev;
        rgb = d;
        hs = dev ? 1'b1 : 1'($urandom);
        model_step(vsv, dev, d, s);
        q.push_back(s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; vs = 1; de = 0; hs = 1;
        #1;
        pin("rst_pix_x", 32'(pix_x), 32'h7ff);
        pin("rst_pix_y", 32'(pix_y), 32'h7ff);
        pin("rst_pix_data", 32'(pix_data), 32'h0);
        pin("rst_flags", 32'({pix_valid, sof, eol, frame_done, frame_err, locked}), 32'h0);
        pin("rst_meas", 32'({meas_h, meas_v}), 32'h0);
        pin("rst_err_cnt", 32'(err_cnt), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    // One frame: optional leading vsync, nl lines, one odd-length line,
    // optional vsync falling mid-line, optional vsync coincident with first de rise.
    task automatic frame(input int nl, input int odd_line, input int odd_len,
                         input int cut_line, input bit cosync, input bit skip_vs);
        if (!skip_vs && !cosync) begin
            step(0, 0); step(0, 0);
            repeat ($urandom_range(1, 3)) step(1, 0);
        end
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == odd_line) ? odd_len : H;
            for (int i = 0; i < len; i++) begin
                bit vsv;
                vsv = 1;
                if (cosync && l == 0 && i < 2) vsv = 0;
                if (l == cut_line && (i == 3 || i == 4)) vsv = 0;
                step(vsv, 1);
            end
            repeat ($urandom_range(1, 4)) step(1, 0);
            if (l == cut_line) return;
        end
        step(1, 0); step(1, 0);
    endtask

    task automatic vclose();
        step(0, 0); step(1, 0); step(1, 0); step(1, 0);
    endtask

    initial begin
        bit pend;
        int t;
        do_reset();

        frame(V, -1, 0, -1, 0, 0);
        frame(V, -1, 0, -1, 0, 0);
        vclose();
        pin("lock_after_2", 32'(locked), 32'h1);
        pin("meas_v_good", 32'(meas_v), 32'(V));
        pin("meas_h_good", 32'(meas_h), 32'(H));
        pin("err_cnt_clean", 32'(err_cnt), 32'h0);

        frame(V, 2, H - 1, -1, 0, 1);
        vclose();
        pin("short_err_cnt", 32'(err_cnt), 32'h1);
        pin("short_unlock", 32'(locked), 32'h0);
        frame(V, -1, 0, -1, 0, 1);
        vclose();
        pin("relock_1", 32'(locked), 32'h0);
        frame(V, -1, 0, -1, 0, 1);
        vclose();
        pin("relock_2", 32'(locked), 32'h1);

        frame(V, 1, H + 1, -1, 0, 1);
        vclose();
        pin("long_err_cnt", 32'(err_cnt), 32'h2);

        frame(V, -1, 0, 2, 0, 1);
        pin("cut_meas_v", 32'(meas_v), 32'h2);
        pin("cut_err_cnt", 32'(err_cnt), 32'h3);
        frame(V, -1, 0, -1, 0, 1);
        frame(V, -1, 0, -1, 1, 0);
        vclose();
        pin("cosync_err_cnt", 32'(err_cnt), 32'h3);
        pin("cosync_lock", 32'(locked), 32'h1);

        pend = 1;
        for (int k = 0; k < 25; k++) begin
            t = $urandom_range(0, 9);
            case (t)
                0: frame(V, $urandom_range(0, V - 1), H - 1, -1, 0, pend);
                1: frame(V, $urandom_range(0, V - 1), H + 1, -1, 0, pend);
                2: frame(V + 1, -1, 0, -1, 0, pend);
                3: frame(V - 1, -1, 0, -1, 0, pend);
                4: frame(V, -1, 0, $urandom_range(0, V - 1), 0, pend);
                5: frame(V, -1, 0, -1, 1, pend);
                default: frame(V, -1, 0, -1, 0, pend);
            endcase
            pend = (t == 4);
        end

        step(0, 0); step(1, 0); step(1, 0);
        repeat (2) begin
            repeat (H) step(1, 1);
            repeat (2) step(1, 0);
        end
        repeat (3) step(1, 1);
        do_reset();
        repeat (H - 3) step(1, 1);
        repeat (2) step(1, 0);
        repeat (2) begin
            repeat (H) step(1, 1);
            repeat (2) step(1, 0);
        end
        frame(V, -1, 0, -1, 0, 0);
        vclose();
        pin("post_rst_err_cnt", 32'(err_cnt), 32'h0);
        pin("post_rst_lock", 32'(locked), 32'h0);
        pin("post_rst_meas_v", 32'(meas_v), 32'(V));

        repeat (300) begin
            step(0, 0);
            step(1, 0);
        end
        repeat (3) step(1, 0);
        pin("err_cnt_sat", 32'(err_cnt), 32'hff);
        pin("sat_meas_v", 32'(meas_v), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tft_rx_capture.md
# tft_rx_capture

Receive-side counterpart of the TFT timing generator: samples an incoming DE-mode RGB565 video stream (hsync/vsync/de/rgb, sync active-low) in the pixel clock domain. It recovers per-pixel coordinates and frame/line markers, and measures active geometry. It checks the geometry against the expected resolution and reports lock and error status. It sits at the input of the capture path, e.g. feeding a frame-buffer writer or a loopback checker on the generator's output.

## Interface
- H_VALID, 11'd480, expected active pixels per line
- V_VALID, 11'd800, expected active lines per frame
- LOCK_FRAMES, 2, consecutive error-free frames required for lock
- tft_clk_9m  in  1  pixel clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- rgb_in  in  16  RGB565 pixel data
- hsync_in  in  1  line sync, active-low (timing only, not used for counting)
- vsync_in  in  1  frame sync, active-low
- de_in  in  1  data enable, active-high
- pix_data  out  16  captured pixel
- pix_x  out  11  pixel column, 0..H_VALID-1; 11'h7ff when pix_valid=0
- pix_y  out  11  pixel row, 0..V_VALID-1; 11'h7ff when pix_valid=0
- pix_valid  out  1  pix_data/pix_x/pix_y valid
- sof  out  1  with pix_valid on pixel (0,0)
- eol  out  1  with pix_valid on pixel x=H_VALID-1
- frame_done  out  1  one-cycle pulse at each frame boundary after the first
- meas_h  out  11  de-high length of last completed line
- meas_v  out  11  line count of last completed frame
- frame_err  out  1  one-cycle pulse, geometry error in the frame just closed
- err_cnt  out  8  saturating error-frame counter
- locked  out  1  LOCK_FRAMES consecutive good frames seen

## Operation
- Stage 1: register all inputs. Edge-detect against the previous stage-1 value. vs_fall is vsync 1→0, de_rise is de 0→1, de_fall is de 1→0.
- FSM states: IDLE, VBLANK, LINE, HBLANK.
  - IDLE (reset state): ignore everything until vs_fall → VBLANK. No frame_done or frame_err for this first boundary; the partial frame is discarded.
  - VBLANK: y_cnt=0, line_cnt=0. de_rise → LINE, x_cnt=0.
  - LINE: each de-high cycle emits a pixel if x_cnt<H_VALID and y_cnt<V_VALID, then x_cnt++. x_cnt saturates at 2047.
  - LINE, on de_fall → HBLANK: meas_h<=x_cnt, line_cnt++. Set line_bad if x_cnt≠H_VALID.
  - HBLANK: de_rise → LINE, y_cnt++ (saturating), x_cnt=0.
  - Any of VBLANK/LINE/HBLANK on vs_fall: close the frame. meas_v<=line_cnt, pulse frame_done. The frame is bad if line_bad, line_cnt≠V_VALID, or vs_fall while in LINE (truncated line). Pulse frame_err if bad. Then → VBLANK and clear line_bad.
- Simultaneous vs_fall and de_rise: close the frame first. The same-cycle pixel is (0,0) of the new frame (sof=1), and the state goes to LINE.
- Pixels beyond H_VALID or V_VALID are suppressed (pix_valid=0) and make the frame bad.
- Lock: good_cnt counts consecutive good frames. locked=1 when good_cnt reaches LOCK_FRAMES. A bad frame clears good_cnt and locked in the same cycle as frame_err.
- err_cnt increments on each frame_err and saturates at 8'd255.

## Timing
- Latency: inputs sampled at edge k appear on pix_* outputs after edge k+1 (2 clocks). sof, eol, and pix_valid are aligned with pix_data.
- frame_done, frame_err, meas_v, and locked update 2 clocks after the vsync falling sample.
- meas_h updates 2 clocks after the de falling sample.
- Reset values:
  - pix_data=0, pix_x=pix_y=11'h7ff
  - pix_valid=sof=eol=frame_done=frame_err=0
  - meas_h=meas_v=0, err_cnt=0, locked=0
  - FSM=IDLE
- Reset mid-frame returns to IDLE. The next frame is discarded as partial; no error is counted.
- All outputs are registered; there are no combinational paths from inputs.

## Structure
- Shared package tft_pkg: coordinate width 11, default H_VALID/V_VALID, FSM state encoding, invalid-coordinate constant 11'h7ff.
- Sub-module tft_sync_edge: input register stage plus vs_fall/de_rise/de_fall detection. The FSM, counters, and checker live in the top module.

## Test plan
- Loopback from generator (H_TOTAL 525, V_TOTAL 1056, 480x800 active) → frame_done every 554400 clocks, meas_h=480, meas_v=800, frame_err never. locked=1 at the 2nd frame_done. pix (0,0) carries sof and (479,y) carries eol.
- One line with 479 de cycles in frame 3 → frame_err at that frame's close, err_cnt=1, locked 0, meas_h=479 after that line. Relock after 2 further good frames.
- One line with 481 de cycles → 481st pixel has pix_valid=0, frame_err=1, meas_h=481.
- vsync falls mid-line at x=100 → frame_err=1, meas_v=line count so far. Next frame captured normally from (0,0).
- vs_fall and de_rise sampled in the same cycle → frame_done, and sof pulses 2 clocks later with pix_x=pix_y=0.
- Assert sys_rst_n low at line 400 → all outputs at reset values. First post-reset vsync produces no frame_done. 300 bad frames → err_cnt holds at 255.
